// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection for the shared system bus (active-low req_/grnt_ handshake)
// Latency: request sampled at edge k -> grant visible after edge k; hand-off on release with no idle cycle
// Backpressure: a master waits while another owns the bus; the watchdog revokes after TIMEOUT held cycles
//
// Ports:
//   clk, rst      - system clock, asynchronous active-low reset
//   m_req_        - per-master request, active low
//   m_grnt_       - per-master grant, active low, registered, at most one bit low
//   owner         - current / most recent owner index (bus mux select)
//   owner_vld     - high while a grant is outstanding
//   timeout       - one-cycle pulse when the watchdog revokes a grant
//   timeout_id    - index of the last master revoked, sticky
module bus_arbiter #(
   parameter int N_MASTERS = 4,
   parameter int TIMEOUT   = 1023,
   parameter int OWN_W     = $clog2(N_MASTERS),
   parameter int CNT_W     = $clog2(TIMEOUT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_MASTERS-1:0] m_req_,
   output logic [N_MASTERS-1:0] m_grnt_,
   output logic [OWN_W-1:0]     owner,
   output logic                 owner_vld,
   output logic                 timeout,
   output logic [OWN_W-1:0]     timeout_id
);

   // With the watchdog disabled CNT_W collapses to 0; keep a 1-bit counter that never moves.
   localparam int               CW         = (CNT_W < 1) ? 1 : CNT_W;
   localparam logic [CW-1:0]    C_TO_LAST  = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
   localparam logic [OWN_W-1:0] C_LAST_RST = OWN_W'(N_MASTERS - 1);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t                 r_state, w_nxt_state;
   logic [OWN_W-1:0]       r_owner, w_nxt_owner;
   logic [OWN_W-1:0]       r_last, w_nxt_last;
   logic [CW-1:0]          r_cnt, w_nxt_cnt;
   logic [N_MASTERS-1:0]   r_mask, w_nxt_mask;
   logic [N_MASTERS-1:0]   r_grnt_, w_nxt_grnt_;
   logic                   r_timeout, w_nxt_timeout;
   logic [OWN_W-1:0]       r_timeout_id, w_nxt_timeout_id;

   logic [N_MASTERS-1:0]   w_own_oh;
   logic [N_MASTERS-1:0]   w_cand;
   logic                   w_own_rel;
   logic                   w_hold_to;
   logic                   w_pick_vld;
   logic [OWN_W-1:0]       w_pick;
   int                     w_dist;
   int                     w_best;

   // Candidates: requesting, not masked, and never the current owner while it holds the bus.
   // Excluding the owner lets release and watchdog revocation share one pick.
   always_comb begin
      w_own_oh = '0;
      w_cand   = '0;
      for (int j = 0; j < N_MASTERS; j++) begin
         w_own_oh[j] = (int'(r_owner) == j);
         w_cand[j]   = !m_req_[j] && !r_mask[j] && !((r_state == S_GRANT) && w_own_oh[j]);
      end
   end

   // Round-robin: the candidate at the smallest rotational distance past r_last wins.
   always_comb begin
      w_pick_vld = 1'b0;
      w_pick     = '0;
      w_best     = N_MASTERS;
      w_dist     = 0;
      for (int j = 0; j < N_MASTERS; j++) begin
         w_dist = (j + N_MASTERS - 1 - int'(r_last)) % N_MASTERS;
         if (w_cand[j] && (w_dist < w_best)) begin
            w_best     = w_dist;
            w_pick_vld = 1'b1;
            w_pick     = OWN_W'(j);
         end
      end
   end

   assign w_own_rel = |(m_req_ & w_own_oh);
   assign w_hold_to = (TIMEOUT != 0) && (r_cnt == C_TO_LAST);

   always_comb begin
      w_nxt_state      = r_state;
      w_nxt_owner      = r_owner;
      w_nxt_last       = r_last;
      w_nxt_cnt        = r_cnt;
      w_nxt_mask       = r_mask & ~m_req_;   // a high request clears the watchdog mask
      w_nxt_timeout    = 1'b0;
      w_nxt_timeout_id = r_timeout_id;
      w_nxt_grnt_      = '1;

      case (r_state)
         S_IDLE: begin
            if (w_pick_vld) begin
               w_nxt_state = S_GRANT;
               w_nxt_owner = w_pick;
               w_nxt_last  = w_pick;
               w_nxt_cnt   = '0;
            end
         end
         S_GRANT: begin
            // Release is checked before the watchdog so a release on the last cycle wins.
            if (w_own_rel || w_hold_to) begin
               if (!w_own_rel) begin
                  w_nxt_timeout    = 1'b1;
                  w_nxt_timeout_id = r_owner;
                  w_nxt_mask       = w_nxt_mask | w_own_oh;
               end
               if (w_pick_vld) begin
                  w_nxt_owner = w_pick;
                  w_nxt_last  = w_pick;
                  w_nxt_cnt   = '0;
               end else begin
                  w_nxt_state = S_IDLE;
               end
            end else if (TIMEOUT != 0) begin
               w_nxt_cnt = r_cnt + CW'(1);
            end
         end
         default: w_nxt_state = S_IDLE;
      endcase

      for (int j = 0; j < N_MASTERS; j++) begin
         w_nxt_grnt_[j] = !((w_nxt_state == S_GRANT) && (int'(w_nxt_owner) == j));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_owner      <= '0;
         r_last       <= C_LAST_RST;
         r_cnt        <= '0;
         r_mask       <= '0;
         r_grnt_      <= '1;
         r_timeout    <= 1'b0;
         r_timeout_id <= '0;
      end else begin
         r_state      <= w_nxt_state;
         r_owner      <= w_nxt_owner;
         r_last       <= w_nxt_last;
         r_cnt        <= w_nxt_cnt;
         r_mask       <= w_nxt_mask;
         r_grnt_      <= w_nxt_grnt_;
         r_timeout    <= w_nxt_timeout;
         r_timeout_id <= w_nxt_timeout_id;
      end
   end

   assign m_grnt_    = r_grnt_;
   assign owner      = r_owner;
   assign owner_vld  = (r_state == S_GRANT);
   assign timeout    = r_timeout;
   assign timeout_id = r_timeout_id;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus random request traffic against a behavioural round-robin model
// Latency: outputs compared 1 time unit after every rising edge
// Backpressure: none; requests are driven on the falling edge
module tb_bus_arbiter;
   localparam int N  = 4;
   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] m_req_;
   logic [N-1:0] m_grnt_;
   logic [1:0]   owner;
   logic         owner_vld;
   logic         timeout;
   logic [1:0]   timeout_id;

   always #5 clk = ~clk;

   bus_arbiter #(.N_MASTERS(N), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .m_req_     (m_req_),
      .m_grnt_    (m_grnt_),
      .owner      (owner),
      .owner_vld  (owner_vld),
      .timeout    (timeout),
      .timeout_id (timeout_id)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: md_own is the owning master or -1, md_hold the granted cycles so far.
   int md_own, md_last, md_hold, md_owner_reg, md_toid;
   bit md_to, md_new;
   bit md_mask [N];
   bit md_el   [N];
   int wait_cnt[N];

   task automatic md_reset();
      md_own = -1; md_last = N - 1; md_hold = 0; md_owner_reg = 0; md_toid = 0; md_to = 0;
      for (int i = 0; i < N; i++) begin md_mask[i] = 0; wait_cnt[i] = 0; end
   endtask

   function automatic int md_pick();
      for (int k = 1; k <= N; k++)
         if (md_el[(md_last + k) % N]) return (md_last + k) % N;
      return -1;
   endfunction

   task automatic md_grant(input int p);
      md_own = p; md_last = p; md_hold = 1; md_new = 1;
   endtask

   task automatic md_step(input logic [N-1:0] req);
      bit r[N]; bit nmask[N]; bit waiting[N]; int p;
      md_new = 0; md_to = 0;
      for (int i = 0; i < N; i++) begin
         r[i]       = req[i];
         md_el[i]   = !r[i] && !md_mask[i];
         nmask[i]   = md_mask[i] && !r[i];
         waiting[i] = md_el[i] && (i != md_own);
      end
      if (md_own < 0) begin
         p = md_pick();
         if (p >= 0) md_grant(p);
      end else if (r[md_own]) begin
         md_el[md_own] = 0;
         p = md_pick();
         if (p >= 0) md_grant(p); else md_own = -1;
      end else if (TO != 0 && md_hold == TO) begin
         md_to = 1; md_toid = md_own; nmask[md_own] = 1; md_el[md_own] = 0;
         p = md_pick();
         if (p >= 0) md_grant(p); else md_own = -1;
      end else begin
         md_hold++;
      end
      for (int i = 0; i < N; i++) md_mask[i] = nmask[i];
      if (md_own >= 0) md_owner_reg = md_own;
      // fairness: ownerships handed to others while a master waits eligibly
      for (int i = 0; i < N; i++) begin
         if (!waiting[i]) wait_cnt[i] = 0;
         else if (md_new && i == md_own) begin
            chk("fair", 32'(wait_cnt[i] <= N), 32'd1);
            wait_cnt[i] = 0;
         end else if (md_new) wait_cnt[i]++;
      end
   endtask

   task automatic compare();
      logic [N-1:0] eg;
      eg = (md_own >= 0) ? ~(4'b0001 << md_own) : 4'b1111;
      chk("grnt",     32'(m_grnt_),    32'(eg));
      chk("owner",    32'(owner),      32'(md_owner_reg));
      chk("vld",      32'(owner_vld),  32'(md_own >= 0));
      chk("timeout",  32'(timeout),    32'(md_to));
      chk("toid",     32'(timeout_id), 32'(md_toid));
      chk("onehot",   32'($countones(~m_grnt_) <= 1), 32'd1);
   endtask

   task automatic cyc(input logic [N-1:0] req);
      @(negedge clk);
      m_req_ = req;
      @(posedge clk);
      md_step(req);
      #1;
      compare();
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] rq;
      int hold, prev, gaps, g;
      bit seen;
      int order[$];
      int exp_ord[6] = '{0, 1, 3, 0, 1, 3};

      rst = 1'b0;
      m_req_ = '1;
      md_reset();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_grnt",  32'(m_grnt_),    32'hf);
      chk("rst_owner", 32'(owner),      32'd0);
      chk("rst_vld",   32'(owner_vld),  32'd0);
      chk("rst_to",    32'(timeout),    32'd0);
      chk("rst_toid",  32'(timeout_id), 32'd0);

      // first grant goes to master 0
      cyc(4'b1110);
      chk("first_grnt", 32'(m_grnt_), 32'he);
      chk("first_own",  32'(owner),   32'd0);
      chk("first_vld",  32'(owner_vld), 32'd1);
      cyc(4'b1111);
      cyc(4'b0111);   // park the round-robin pointer on master 3
      cyc(4'b1111);

      // masters 0, 1, 3 requesting, each releasing after 3 granted cycles
      hold = 0; prev = -1; gaps = 0;
      for (int c = 0; c < 25; c++) begin
         rq = 4'b0100;
         if (owner_vld) begin
            if (int'(owner) == prev) hold++;
            else begin hold = 1; prev = int'(owner); order.push_back(prev); end
            if (hold == 3) rq[owner] = 1'b1;
         end else if (order.size() > 0) gaps++;
         cyc(rq);
      end
      chk("rr_gaps", 32'(gaps), 32'd0);
      chk("rr_count", 32'(order.size() >= 6), 32'd1);
      if (order.size() >= 6)
         for (int k = 0; k < 6; k++) chk("rr_order", 32'(order[k]), 32'(exp_ord[k]));

      // owner 2 releases with nobody else requesting
      cyc(4'b1111);
      repeat (3) cyc(4'b1011);
      cyc(4'b1111);
      chk("rel_grnt",  32'(m_grnt_),   32'hf);
      chk("rel_vld",   32'(owner_vld), 32'd0);
      chk("rel_owner", 32'(owner),     32'd2);

      // watchdog: master 1 holds, master 2 waiting
      cyc(4'b1101);
      g = 0; seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (owner_vld && owner == 2'd1) g++;
         cyc(4'b1001);
         seen = timeout;
      end
      chk("to_seen",   32'(seen),       32'd1);
      chk("to_cycles", 32'(g),          32'(TO));
      chk("to_id",     32'(timeout_id), 32'd1);
      chk("to_owner",  32'(owner),      32'd2);
      cyc(4'b1001);
      cyc(4'b1101);   // 2 releases, 1 still masked
      chk("mask_grnt", 32'(m_grnt_), 32'hf);
      cyc(4'b1101);
      chk("mask_hold", 32'(m_grnt_), 32'hf);
      cyc(4'b1111);
      cyc(4'b1101);
      chk("unmask_own", 32'(owner), 32'd1);
      cyc(4'b1101);

      // asynchronous reset mid-grant
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_grnt", 32'(m_grnt_),   32'hf);
      chk("arst_vld",  32'(owner_vld), 32'd0);
      md_reset();
      m_req_ = '1;
      @(negedge clk);
      rst = 1'b1;
      cyc(4'b0000);
      chk("arst_first", 32'(owner), 32'd0);
      cyc(4'b1111);

      // random traffic
      rq = '1;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 5) == 0) rq = rq ^ (4'b0001 << i);
         cyc(rq);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
